testblock_s_axi_regs: RTL and testbench

AXI4-Lite slave register file for the Testblock IP: the responder end of the S00_AXI interface driven by the master VIP in the block-level bench. It holds four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC, honours write strobes, and returns OKAY/SLVERR responses. It exports register contents and per-register write pulses to Testblock user logic.

---
 rtl/testblock_s_axi_regs.sv | 193 +++++++++++++++++++
 tb/tb_testblock_s_axi_regs.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/testblock_s_axi_regs.sv
// AXI4-Lite slave register file for Testblock: four 32-bit R/W registers with byte strobes,
// SLVERR on out-of-range addresses, exported register contents and per-register write pulses.
module testblock_s_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [2:0]                    s00_axi_awprot,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [31:0]                   s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [2:0]                    s00_axi_arprot,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [31:0]                   s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    output logic [127:0]                  slv_reg_o,
    output logic [3:0]                    wr_pulse_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2} rstate_t;

    wstate_t     wstate_q;
    rstate_t     rstate_q;
    logic [31:0] regs_q [4];
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;
    logic [3:0]  wr_pulse_q;

    logic        aw_oor_s;
    logic        ar_oor_s;
    logic [1:0]  wr_idx_s;
    logic [1:0]  rd_idx_s;
    logic [31:0] wr_data_d;
    logic        unused_s;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    // Any address bit above the 16-byte window makes the access out of range.
    generate
        if (C_S_AXI_ADDR_WIDTH > 4) begin : g_oor
            assign aw_oor_s = |s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:4];
            assign ar_oor_s = |s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4];
        end else begin : g_no_oor
            assign aw_oor_s = 1'b0;
            assign ar_oor_s = 1'b0;
        end
    endgenerate

    assign unused_s = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    assign wr_idx_s = s00_axi_awaddr[3:2];
    assign rd_idx_s = s00_axi_araddr[3:2];

    // Strobe-merged next value for the addressed register.
    always_comb begin
        wr_data_d = apply_strb(regs_q[wr_idx_s], s00_axi_wdata, s00_axi_wstrb);
    end

    // Write channel FSM, register storage and write pulses.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wstate_q   <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                regs_q[k] <= 32'h0000_0000;
            end
        end else begin
            wr_pulse_q <= 4'b0000;
            case (wstate_q)
                W_IDLE: begin
                    if (s00_axi_awvalid && s00_axi_wvalid) begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_ACK;
                    end
                end
                W_ACK: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    wstate_q  <= W_RESP;
                    if (aw_oor_s) begin
                        bresp_q <= RESP_SLVERR;
                    end else begin
                        bresp_q              <= RESP_OKAY;
                        regs_q[wr_idx_s]     <= wr_data_d;
                        wr_pulse_q[wr_idx_s] <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s00_axi_bready) begin
                        bvalid_q <= 1'b0;
                        wstate_q <= W_IDLE;
                    end
                end
                default: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    wstate_q  <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM; data is sampled from the pre-write register value.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= 32'h0000_0000;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (s00_axi_arvalid) begin
                        arready_q <= 1'b1;
                        rstate_q  <= R_ACK;
                    end
                end
                R_ACK: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rstate_q  <= R_DATA;
                    if (ar_oor_s) begin
                        rdata_q <= 32'h0000_0000;
                        rresp_q <= RESP_SLVERR;
                    end else begin
                        rdata_q <= regs_q[rd_idx_s];
                        rresp_q <= RESP_OKAY;
                    end
                end
                R_DATA: begin
                    if (s00_axi_rready) begin
                        rvalid_q <= 1'b0;
                        rstate_q <= R_IDLE;
                    end
                end
                default: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                    rstate_q  <= R_IDLE;
                end
            endcase
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;
    assign slv_reg_o       = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
    assign wr_pulse_o      = wr_pulse_q;

endmodule

// File: tb/tb_testblock_s_axi_regs.sv
// Self-checking bench for testblock_s_axi_regs: table-driven register accesses plus
// hand-written sequences for lone channels, backpressure, read/write collision and reset.
module tb_testblock_s_axi_regs;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          areset;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb, wr_pulse;
    logic [1:0]    bresp, rresp;
    logic [127:0]  slv_reg;

    int n_checks = 0;
    int n_errors = 0;

    testblock_s_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW)) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .slv_reg_o(slv_reg), .wr_pulse_o(wr_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [3:0]  pulse;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [3:0] pulse);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        check("wr_ready", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_bvalid", bvalid, 1'b1);
        resp  = bresp;
        pulse = wr_pulse;
        tick();
        check("wr_bvalid_drop_pulse_clear", {bvalid, wr_pulse}, 5'b0_0000);
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [1:0] resp, output logic [31:0] d);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        tick();
        check("rd_arready", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        check("rd_rvalid", rvalid, 1'b1);
        resp = rresp;
        d    = rdata;
        tick();
        check("rd_rvalid_drop", rvalid, 1'b0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [3:0]  pulse;
        logic [31:0] d;
        logic        seen;

        vecs[0]  = '{1'b1, 6'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0, 4'b0001};
        vecs[1]  = '{1'b1, 6'h04, 32'h0000_0002, 4'hF, 2'b00, 32'h0, 4'b0010};
        vecs[2]  = '{1'b1, 6'h08, 32'h0000_0003, 4'hF, 2'b00, 32'h0, 4'b0100};
        vecs[3]  = '{1'b1, 6'h0C, 32'h0000_0004, 4'hF, 2'b00, 32'h0, 4'b1000};
        vecs[4]  = '{1'b0, 6'h00, 32'h0, 4'h0, 2'b00, 32'h0000_0001, 4'b0000};
        vecs[5]  = '{1'b0, 6'h04, 32'h0, 4'h0, 2'b00, 32'h0000_0002, 4'b0000};
        vecs[6]  = '{1'b0, 6'h08, 32'h0, 4'h0, 2'b00, 32'h0000_0003, 4'b0000};
        vecs[7]  = '{1'b0, 6'h0C, 32'h0, 4'h0, 2'b00, 32'h0000_0004, 4'b0000};
        vecs[8]  = '{1'b1, 6'h04, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0, 4'b0010};
        vecs[9]  = '{1'b1, 6'h04, 32'hAABB_CCDD, 4'b0101, 2'b00, 32'h0, 4'b0010};
        vecs[10] = '{1'b0, 6'h04, 32'h0, 4'h0, 2'b00, 32'hFFBB_FFDD, 4'b0000};
        vecs[11] = '{1'b1, 6'h09, 32'h1234_5678, 4'b0000, 2'b00, 32'h0, 4'b0100};
        vecs[12] = '{1'b0, 6'h0A, 32'h0, 4'h0, 2'b00, 32'h0000_0003, 4'b0000};
        vecs[13] = '{1'b1, 6'h10, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0, 4'b0000};
        vecs[14] = '{1'b0, 6'h10, 32'h0, 4'h0, 2'b10, 32'h0000_0000, 4'b0000};
        vecs[15] = '{1'b0, 6'h3C, 32'h0, 4'h0, 2'b10, 32'h0000_0000, 4'b0000};
        vecs[16] = '{1'b1, 6'h0E, 32'h0000_1100, 4'b0010, 2'b00, 32'h0, 4'b1000};
        vecs[17] = '{1'b0, 6'h0C, 32'h0, 4'h0, 2'b00, 32'h0000_1104, 4'b0000};

        areset = 1'b1; awaddr = '0; araddr = '0; awprot = 3'b000; arprot = 3'b000;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
        bready = 1'b1; rready = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        check("reset_regs", slv_reg, 128'h0);
        check("reset_ctrl", {awready, wready, arready, bvalid, rvalid, bresp, rresp, wr_pulse},
              15'h0);
        check("reset_rdata", rdata, 32'h0);
        tick();

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].resp);
                check($sformatf("vec%0d_pulse", i), pulse, vecs[i].pulse);
            end else begin
                axi_read(vecs[i].addr, resp, d);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].resp);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
            end
            if (i == 7) begin
                check("slv_reg_after_fill", slv_reg,
                      128'h00000004_00000003_00000002_00000001);
            end
        end
        check("slv_reg_after_table", slv_reg, 128'h00001104_00000003_FFBBFFDD_00000001);

        // Lone AW for five cycles, then W arrives.
        awaddr = 6'h08; wdata = 32'h0000_0055; wstrb = 4'hF; awvalid = 1'b1; bready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (awready || wready) seen = 1'b1;
        end
        check("lone_aw_no_ready", seen, 1'b0);
        wvalid = 1'b1;
        tick();
        check("lone_aw_ready", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("lone_aw_bvalid", bvalid, 1'b1);
        check("lone_aw_reg2", slv_reg[95:64], 32'h0000_0055);
        tick();

        // B backpressure with a second write pending.
        awaddr = 6'h00; wdata = 32'h0000_0077; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b0;
        tick();
        tick();
        check("bp_first_bvalid", {bvalid, bresp}, 3'b100);
        check("bp_reg0", slv_reg[31:0], 32'h0000_0077);
        awaddr = 6'h0C; wdata = 32'h0000_0099;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (!bvalid || bresp != 2'b00 || awready || wready) seen = 1'b1;
        end
        check("bp_hold", seen, 1'b0);
        bready = 1'b1;
        tick();
        check("bp_after_handshake", {bvalid, awready}, 2'b00);
        tick();
        check("bp_second_ready", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_second_bvalid", bvalid, 1'b1);
        check("bp_reg3", slv_reg[127:96], 32'h0000_0099);
        tick();

        // R backpressure: data stable while rready is low.
        araddr = 6'h08; arvalid = 1'b1; rready = 1'b0;
        tick();
        tick();
        arvalid = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (!rvalid || rdata != 32'h0000_0055 || rresp != 2'b00) seen = 1'b1;
        end
        check("rbp_hold", seen, 1'b0);
        rready = 1'b1;
        tick();
        check("rbp_drop", rvalid, 1'b0);

        // Read and write of the same register accepted in the same cycle.
        awaddr = 6'h04; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 6'h04; arvalid = 1'b1;
        tick();
        check("coll_readies", {awready, arready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("coll_old_value", rdata, 32'hFFBB_FFDD);
        tick();
        axi_read(6'h04, resp, d);
        check("coll_new_value", d, 32'h0BAD_F00D);

        // Reset while a write response is pending.
        awaddr = 6'h00; wdata = 32'h0000_0005; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b0;
        tick();
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("rst_mid_bvalid", bvalid, 1'b1);
        check("rst_mid_reg0", slv_reg[31:0], 32'h0000_0005);
        areset = 1'b1;
        tick();
        areset = 1'b0; bready = 1'b1;
        check("rst_mid_drop", {bvalid, slv_reg}, 129'h0);
        axi_read(6'h00, resp, d);
        check("rst_mid_read", {resp, d}, 34'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
